// File: rtl/maquina_param.sv
// Flow-control FSM for the FIFO interconnect: latches and validates per-class
// thresholds, then tracks FIFO activity with IDLE hysteresis and sticky errors.
module maquina_param #(
    parameter int NUM_FIFOS = 5,
    parameter int NUM_PAIRS = 3,
    parameter int UMBRAL_W  = 2,
    parameter int IDLE_DLY  = 4,
    parameter int CNT_W     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          init,
    input  logic                          err_clr,
    input  logic [NUM_PAIRS*UMBRAL_W-1:0] umbral_alto,
    input  logic [NUM_PAIRS*UMBRAL_W-1:0] umbral_bajo,
    input  logic [NUM_FIFOS-1:0]          fifo_empties,
    input  logic [NUM_FIFOS-1:0]          fifo_errors,
    output logic [NUM_PAIRS*UMBRAL_W-1:0] umbral_alto_o,
    output logic [NUM_PAIRS*UMBRAL_W-1:0] umbral_bajo_o,
    output logic                          cfg_err,
    output logic                          idle_out,
    output logic                          active_out,
    output logic                          error_out,
    output logic [NUM_FIFOS-1:0]          errors_out,
    output logic [CNT_W-1:0]              err_cnt
);

    localparam int IC_W = (IDLE_DLY < 2) ? 1 : $clog2(IDLE_DLY + 1);
    localparam logic [IC_W-1:0] IDLE_LAST = IC_W'(IDLE_DLY - 1);

    typedef enum logic [4:0] {
        S_RESET  = 5'b00001,
        S_INIT   = 5'b00010,
        S_IDLE   = 5'b00100,
        S_ACTIVE = 5'b01000,
        S_ERROR  = 5'b10000
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [IC_W-1:0] idle_cnt;
    logic            cfg_bad;
    logic            all_empty;
    logic            any_error;
    logic            err_release;

    // Threshold check on the live inputs; a pair is bad when bajo exceeds alto.
    always_comb begin
        // NOTE: default first so no path leaves cfg_bad unassigned (no latch).
        cfg_bad = 1'b0;
        for (int k = 0; k < NUM_PAIRS; k++) begin
            if (umbral_bajo[k*UMBRAL_W +: UMBRAL_W] > umbral_alto[k*UMBRAL_W +: UMBRAL_W])
                cfg_bad = 1'b1;
        end
    end

    assign all_empty   = &fifo_empties;
    assign any_error   = |fifo_errors;
    assign err_release = err_clr && !any_error;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!reset) state <= S_RESET;
        else        state <= next_state;
    end

    always_comb begin
        next_state = S_RESET;
        case (state)
            S_RESET:  next_state = S_INIT;
            S_INIT:   next_state = (init || cfg_bad) ? S_INIT : S_IDLE;
            S_IDLE: begin
                if (init)            next_state = S_INIT;
                else if (any_error)  next_state = S_ERROR;
                else if (!all_empty) next_state = S_ACTIVE;
                else                 next_state = S_IDLE;
            end
            S_ACTIVE: begin
                if (init)                                   next_state = S_INIT;
                else if (any_error)                         next_state = S_ERROR;
                else if (all_empty && idle_cnt == IDLE_LAST) next_state = S_IDLE;
                else                                        next_state = S_ACTIVE;
            end
            S_ERROR:  next_state = err_release ? S_INIT : S_ERROR;
            default:  next_state = S_RESET;
        endcase
    end

    always_comb begin
        idle_out   = (state == S_IDLE);
        active_out = (state == S_ACTIVE);
        error_out  = (state == S_ERROR);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            umbral_alto_o <= '0;
            umbral_bajo_o <= '0;
            cfg_err       <= 1'b0;
            errors_out    <= '0;
            err_cnt       <= '0;
            idle_cnt      <= '0;
        end else begin
            if (state == S_INIT) begin
                umbral_alto_o <= umbral_alto;
                umbral_bajo_o <= umbral_bajo;
                cfg_err       <= cfg_bad;
            end

            if (state == S_ERROR && err_release) errors_out <= '0;
            else                                 errors_out <= errors_out | fifo_errors;

            if ((state == S_IDLE || state == S_ACTIVE) && next_state == S_ERROR
                && err_cnt != {CNT_W{1'b1}})
                err_cnt <= err_cnt + CNT_W'(1);

            // Hysteresis only runs while ACTIVE persists, so every entry starts at zero.
            if (state == S_ACTIVE && next_state == S_ACTIVE)
                idle_cnt <= all_empty ? idle_cnt + IC_W'(1) : '0;
            else
                idle_cnt <= '0;
        end
    end

endmodule
